// File: rtl/pair_scheduler.sv
// pair_scheduler: walks every ordered body pair (i, j), i != j, for the
// all-pairs acceleration phase. It drives RAM read addresses one pair per
// cycle and carries a {valid, i, first, last} tag through a delay line that
// is matched to the RAM-read plus getAccl latency. A busy/done handshake
// reports completion to the top-level state machine.
//
// state | meaning
// IDLE  | waiting for start; N is latched on start
// ISSUE | issuing one pair per non-stalled cycle, i-major / j-minor
// DRAIN | all pairs issued; waiting for the delay line to empty

module pair_scheduler #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int PIPE_LAT        = 123
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       stall,
    input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
    output logic                       busy,
    output logic                       done,
    output logic                       issue_valid,
    output logic [BODY_ADDR_WIDTH-1:0] rd_i,
    output logic [BODY_ADDR_WIDTH-1:0] rd_j,
    output logic                       out_valid,
    output logic [BODY_ADDR_WIDTH-1:0] out_i,
    output logic                       out_first,
    output logic                       out_last
);

    localparam int AW = BODY_ADDR_WIDTH;
    localparam int CW = BODY_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic          done_q, done_d;

    logic [PIPE_LAT-1:0] dl_valid_q, dl_valid_d;
    logic [AW-1:0]       dl_i_q     [PIPE_LAT];
    logic [AW-1:0]       dl_i_d     [PIPE_LAT];
    logic [PIPE_LAT-1:0] dl_first_q, dl_first_d;
    logic [PIPE_LAT-1:0] dl_last_q,  dl_last_d;

    logic          issue_fire;
    logic [CW-1:0] i_ext, j_ext;
    logic [CW-1:0] n_m1, n_m2;
    logic [CW-1:0] last_j;
    logic          at_last_j;
    logic          on_last_i;
    logic          is_first_j;
    logic [AW-1:0] j_next;

    // Pair-walk bookkeeping: end-of-row detection and the next j, skipping j == i.
    always_comb begin
        issue_fire = (state_q == ISSUE) && !stall;
        i_ext      = {1'b0, i_q};
        j_ext      = {1'b0, j_q};
        n_m1       = n_q - CW'(1);
        n_m2       = n_q - CW'(2);
        on_last_i  = (i_ext == n_m1);
        last_j     = on_last_i ? n_m2 : n_m1;
        at_last_j  = (j_ext == last_j);
        is_first_j = (i_q == '0) ? (j_q == AW'(1)) : (j_q == '0);
        // j + 1 == i can only happen mid-row, so j + 2 never passes N-1 here
        j_next     = ((j_ext + CW'(1)) == i_ext) ? (j_q + AW'(2)) : (j_q + AW'(1));
    end

    // Next-state, counter and delay-line computation; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        i_d        = i_q;
        j_d        = j_q;
        done_d     = 1'b0;

        dl_valid_d = {dl_valid_q[PIPE_LAT-2:0], issue_fire};
        dl_first_d = {dl_first_q[PIPE_LAT-2:0], is_first_j};
        dl_last_d  = {dl_last_q[PIPE_LAT-2:0],  at_last_j};
        dl_i_d[0]  = i_q;
        for (int k = 1; k < PIPE_LAT; k++) begin
            dl_i_d[k] = dl_i_q[k-1];
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    n_d     = num_bodies;
                    i_d     = '0;
                    j_d     = AW'(1);
                    state_d = (num_bodies >= CW'(2)) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                if (issue_fire) begin
                    if (at_last_j) begin
                        if (on_last_i) begin
                            state_d = DRAIN;
                        end else begin
                            i_d = i_q + AW'(1);
                            j_d = '0;
                        end
                    end else begin
                        j_d = j_next;
                    end
                end
            end
            DRAIN: begin
                // the final stage leaves on this edge, so only earlier stages matter
                if (dl_valid_q[PIPE_LAT-2:0] == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            done_d     = 1'b0;
            dl_valid_d = '0;
        end
    end

    // State, counters and delay line; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            done_q     <= 1'b0;
            dl_valid_q <= '0;
            dl_first_q <= '0;
            dl_last_q  <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                dl_i_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            done_q     <= done_d;
            dl_valid_q <= dl_valid_d;
            dl_first_q <= dl_first_d;
            dl_last_q  <= dl_last_d;
            dl_i_q     <= dl_i_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign issue_valid = issue_fire;
    assign rd_i        = i_q;
    assign rd_j        = j_q;
    assign out_valid   = dl_valid_q[PIPE_LAT-1];
    assign out_i       = dl_i_q[PIPE_LAT-1];
    assign out_first   = dl_first_q[PIPE_LAT-1];
    assign out_last    = dl_last_q[PIPE_LAT-1];

endmodule

// File: tb/tb_pair_scheduler.sv
// Bench for pair_scheduler with a short delay line (PIPE_LAT=4).
// Stimulus pushes expected issues, results and done pulses (each stamped with
// its cycle) into queues; a negedge monitor pops and compares them.

module tb_pair_scheduler;

    localparam int BW  = 9;
    localparam int LAT = 4;

    typedef struct { int cyc; int i; int j; } iss_t;
    typedef struct { int cyc; int i; bit first; bit last; } out_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stall = 1'b0;
    logic [BW:0]   num_bodies = '0;
    logic          busy, done, issue_valid, out_valid, out_first, out_last;
    logic [BW-1:0] rd_i, rd_j, out_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    iss_t exp_iss [$];
    out_t exp_out [$];
    int   exp_done[$];

    // hand-computed pair table for N=3
    int pi3[6] = '{0, 0, 1, 1, 2, 2};
    int pj3[6] = '{1, 2, 0, 2, 0, 1};
    bit pf3[6] = '{1, 0, 1, 0, 1, 0};
    bit pl3[6] = '{0, 1, 0, 1, 0, 1};

    pair_scheduler #(.BODIES(512), .BODY_ADDR_WIDTH(BW), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
        .num_bodies(num_bodies), .busy(busy), .done(done),
        .issue_valid(issue_valid), .rd_i(rd_i), .rd_j(rd_j),
        .out_valid(out_valid), .out_i(out_i), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required summary before it");
        $fatal(1, "watchdog");
    end

    // Monitor: every presented issue, result and done pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid) begin
                checks++;
                if (exp_iss.size() == 0) begin
                    errors++;
                    $display("FAIL issue: unexpected (%0d,%0d) at cycle %0d, required none", rd_i, rd_j, cyc);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    if (e.cyc != cyc || int'(rd_i) != e.i || int'(rd_j) != e.j) begin
                        errors++;
                        $display("FAIL issue: got (%0d,%0d)@%0d, required (%0d,%0d)@%0d",
                                 rd_i, rd_j, cyc, e.i, e.j, e.cyc);
                    end
                end
            end
            if (out_valid) begin
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected out_i=%0d at cycle %0d, required none", out_i, cyc);
                end else begin
                    out_t o;
                    o = exp_out.pop_front();
                    if (o.cyc != cyc || int'(out_i) != o.i || out_first != o.first || out_last != o.last) begin
                        errors++;
                        $display("FAIL result: got i=%0d f=%0d l=%0d @%0d, required i=%0d f=%0d l=%0d @%0d",
                                 out_i, out_first, out_last, cyc, o.i, o.first, o.last, o.cyc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done: unexpected pulse at cycle %0d, required none", cyc);
                end else begin
                    int d;
                    d = exp_done.pop_front();
                    if (d != cyc || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done: got cycle %0d busy=%0d, required cycle %0d busy=0", cyc, busy, d);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic do_start(input int n, output int t0);
        next_cycle();
        num_bodies = (BW+1)'(n);
        start = 1'b1;
        t0 = cyc;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic push_n3(input int t0, input int stall_len);
        for (int k = 0; k < 6; k++) begin
            int ic;
            ic = t0 + 1 + k + ((k >= 1) ? stall_len : 0);
            exp_iss.push_back('{ic, pi3[k], pj3[k]});
            exp_out.push_back('{ic + LAT, pi3[k], pf3[k], pl3[k]});
        end
        exp_done.push_back(t0 + 11 + stall_len);
    endtask

    task automatic push_model(input int t0, input int n);
        int c;
        c = t0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    c++;
                    exp_iss.push_back('{c, i, j});
                    exp_out.push_back('{c + LAT, i, (j == ((i == 0) ? 1 : 0)),
                                       (j == ((i == n-1) ? n-2 : n-1))});
                end
            end
        end
        exp_done.push_back((n < 2) ? t0 + 2 : c + LAT + 1);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_iss.size() + exp_out.size() + exp_done.size()) != 0 && k < budget) begin
            next_cycle();
            k++;
        end
        checks++;
        if ((exp_iss.size() + exp_out.size() + exp_done.size()) != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d/%0d/%0d expectations left, required 0/0/0",
                     name, exp_iss.size(), exp_out.size(), exp_done.size());
            exp_iss.delete();
            exp_out.delete();
            exp_done.delete();
        end
        next_cycle();
        next_cycle();
    endtask

    initial begin
        int t0, t1;

        #12;
        check("reset outputs", {busy, done, issue_valid, rd_i, rd_j, out_valid, out_i, out_first, out_last}, '0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("idle after reset", {busy, done, issue_valid, out_valid}, '0);

        // full pass N=3
        do_start(3, t0);
        check("busy after start", busy, 1'b1);
        push_n3(t0, 0);
        drain("full pass", 60);

        // stall cycles t0+2 and t0+3
        do_start(3, t0);
        push_n3(t0, 2);
        next_cycle();
        stall = 1'b1;
        next_cycle();
        next_cycle();
        stall = 1'b0;
        drain("stall pass", 60);

        // abort in cycle t0+5 of an N=4 pass, restart with N=3 next cycle
        do_start(4, t0);
        exp_iss.push_back('{t0 + 1, 0, 1});
        exp_iss.push_back('{t0 + 2, 0, 2});
        exp_iss.push_back('{t0 + 3, 0, 3});
        exp_iss.push_back('{t0 + 4, 1, 0});
        exp_iss.push_back('{t0 + 5, 1, 2});
        exp_out.push_back('{t0 + 5, 0, 1'b1, 1'b0});
        for (int k = 0; k < 4; k++) next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check("idle after abort", busy, 1'b0);
        num_bodies = 3;
        start = 1'b1;
        t1 = cyc;
        next_cycle();
        start = 1'b0;
        push_n3(t1, 0);
        drain("abort restart", 60);

        // degenerate N
        do_start(1, t0);
        check("busy N=1", busy, 1'b1);
        push_model(t0, 1);
        drain("N=1", 20);
        do_start(0, t0);
        check("busy N=0", busy, 1'b1);
        push_model(t0, 0);
        drain("N=0", 20);
        do_start(2, t0);
        push_model(t0, 2);
        drain("N=2", 30);

        // N=4 pass
        do_start(4, t0);
        push_model(t0, 4);
        drain("N=4", 60);

        // start pulse and num_bodies change mid-pass are ignored
        do_start(3, t0);
        push_n3(t0, 0);
        next_cycle();
        start = 1'b1;
        num_bodies = 5;
        next_cycle();
        start = 1'b0;
        drain("start while busy", 60);

        // start with abort in IDLE: no pass
        num_bodies = 3;
        next_cycle();
        start = 1'b1;
        abort = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort stays idle", busy, 1'b0);
        next_cycle();
        check("start+abort still idle", busy, 1'b0);

        // asynchronous reset in the middle of ISSUE
        do_start(4, t0);
        exp_iss.push_back('{t0 + 1, 0, 1});
        exp_iss.push_back('{t0 + 2, 0, 2});
        exp_iss.push_back('{t0 + 3, 0, 3});
        next_cycle();
        next_cycle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset outputs", {busy, done, issue_valid, rd_i, rd_j, out_valid, out_i, out_first, out_last}, '0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drain("after reset", 10);
        do_start(3, t0);
        push_n3(t0, 0);
        drain("pass after reset", 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pair_scheduler.md
# pair_scheduler

Sequencer for the all-pairs acceleration phase of the n-body engine. It walks every ordered body pair (i, j) with i ≠ j and drives the i/j read addresses into the position/mass RAMs, one pair per cycle. It carries a per-pair tag through a delay line matched to RAM-read plus getAccl latency, so the downstream velocity accumulator knows which body each result belongs to and where each body's run of results starts and ends. It reports completion to the top-level state machine with a busy/done handshake.

## Interface
- BODIES, 512: maximum body count.
- BODY_ADDR_WIDTH, $clog2(BODIES): body index width.
- PIPE_LAT, 123: cycles from an issue to its result, i.e. 1 RAM read + getAccl latency (2·20 + 5·11 + 27). Must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a pass. Sampled only in IDLE.
- abort  in  1  cancel the pass. Effective in any state.
- stall  in  1  hold issuing this cycle.
- num_bodies  in  BODY_ADDR_WIDTH+1  body count N, legal 0..BODIES. Latched on start.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse when a pass completes.
- issue_valid  out  1  rd_i/rd_j carry a pair this cycle.
- rd_i  out  BODY_ADDR_WIDTH  i read address.
- rd_j  out  BODY_ADDR_WIDTH  j read address.
- out_valid  out  1  the getAccl output this cycle belongs to a real pair.
- out_i  out  BODY_ADDR_WIDTH  body i of that pair.
- out_first  out  1  first pair for out_i.
- out_last  out  1  last pair for out_i.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - start=1 and abort=0: latch N, reset i=0 and j=first_j(0).
  - Go to ISSUE if N ≥ 2; otherwise go to DRAIN with nothing issued.
- **ISSUE**
  - Each cycle with stall=0: issue_valid=1, rd_i=i, rd_j=j.
  - Advance j to the next value ≠ i. When j passes N-1: i += 1 and j = first_j(i).
  - first_j(i) = 1 if i=0, else 0. last_j(i) = N-2 if i=N-1, else N-1.
  - After issuing (N-1, N-2), go to DRAIN.
  - stall=1: issue_valid=0, counters hold, a bubble enters the delay line.
- **DRAIN**: wait until no valid entry remains in the delay line, then go to IDLE and pulse done.
- Issue order is i-major, j-minor. Total issues = N·(N-1).
- Delay line: PIPE_LAT stages of {valid, i, first, last}. It shifts every cycle regardless of stall. out_* come from the final stage.
- abort: next state IDLE. All delay-line valid bits cleared. No done pulse. Other tags don't care.
- start while not IDLE is ignored. start and abort in the same IDLE cycle: abort wins, no pass begins.
- The latched N is immune to num_bodies changes mid-pass.

## Timing
- **Reset values**: every output 0 (busy, done, issue_valid, rd_i, rd_j, out_valid, out_i, out_first, out_last). State IDLE, delay line invalid. rst mid-pass behaves like abort, asynchronously.
- **Start latency**: start sampled at edge t → busy=1 and first issue_valid in cycle t+1 (if stall=0).
- **rd_i/rd_j**: driven from registered counters; they hold their value when issue_valid=0.
- **Result latency**: an issue in cycle c produces out_valid in cycle c+PIPE_LAT with its tag. The delay line has no stall path.
- **Completion, no stalls**:
  - Last issue in cycle t+N(N-1).
  - Final out_valid (out_i=N-1, out_last=1) in cycle t+N(N-1)+PIPE_LAT.
  - done=1 and busy=0 in the following cycle.
- **N ∈ {0,1}**: busy=1 in cycle t+1, done=1 and busy=0 in cycle t+2, no issue_valid.
- done never coincides with busy=1. A new start is accepted in the done cycle (state is IDLE).
- Each stall cycle delays completion by exactly one cycle.

## Test plan
- **Full pass**: PIPE_LAT=4, N=3, start → issues (0,1)(0,2)(1,0)(1,2)(2,0)(2,1) in cycles 1–6.
  - out_valid in cycles 5–10.
  - first on (0,1)(1,0)(2,0); last on (0,2)(1,2)(2,1).
  - done in cycle 11.
- **Stall**: N=3, stall high cycles 2–3 → issues at cycles 1,4,5,6,7,8. out_valid gaps at 6–7. done in cycle 13.
- **Abort mid-pass**: N=4, abort at cycle 5 → IDLE in cycle 6, out_valid stays 0 afterwards, no done.
  - Restart with start next cycle → clean (0,1) first issue.
- **Degenerate N**: N=1 and N=0 → no issue_valid, done pulses 2 cycles after start. N=2 → exactly 2 issues, both first=last=1.
- **Start while busy, num_bodies change**: start pulses and num_bodies changes while busy → ignored, pair count unchanged. start+abort in IDLE → stays IDLE.
- **Async reset**: rst asserted mid-ISSUE between clock edges → all outputs 0 immediately. After release, a fresh pass completes correctly.
